// File: rtl/hamming16_link.sv
// Serial Hamming(16,11) SECDED link: bit-serial frame loader and encoder,
// error-injection channel that can flip up to two positions, and serial decoder.
module hamming16_link (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_valid,
    input  logic        err_en,
    input  logic [3:0]  err_addr1,
    input  logic [3:0]  err_addr2,
    output logic        busy,
    output logic        enc_parity,
    output logic [3:0]  enc_group,
    output logic        line_bit,
    output logic        done,
    output logic        dec_parity,
    output logic [3:0]  dec_check,
    output logic        no_err,
    output logic        single_err,
    output logic        double_err,
    output logic [10:0] data_out
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_ENC  = 2'd1,
        ST_XMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r;
    logic [15:0] mem_r;
    logic [15:0] rx_r;

    logic        flip_s;
    logic        p1_s, p2_s, p4_s, p8_s;
    logic [15:0] enc_frame_s;
    logic        par_next_s;
    logic [3:0]  chk_next_s;
    logic [15:0] rx_full_s;
    logic [15:0] corrected_s;

    // Positions 0,1,2,4,8 carry parity, so loaded data there is discarded.
    function automatic logic is_reserved(input logic [3:0] pos);
        return (pos == 4'd0) || (pos == 4'd1) || (pos == 4'd2) ||
               (pos == 4'd4) || (pos == 4'd8);
    endfunction

    function automatic logic group_parity(input logic [15:0] f, input logic [15:0] mask);
        return ^(f & mask);
    endfunction

    function automatic logic [10:0] extract_data(input logic [15:0] f);
        return {f[15], f[14], f[13], f[12], f[11], f[10], f[9], f[7], f[6], f[5], f[3]};
    endfunction

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (din_valid && (cnt_r == 4'd15)) state_s = ST_ENC;
                else                               state_s = ST_LOAD;
            end
            ST_ENC:  state_s = ST_XMIT;
            ST_XMIT: begin
                if (cnt_r == 4'd15) state_s = ST_DONE;
                else                state_s = ST_XMIT;
            end
            ST_DONE: begin
                if (din_valid) state_s = ST_LOAD;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_LOAD;
        endcase
    end

    // Channel bit, encoder parity and decoder look-ahead for the final XMIT edge.
    always_comb begin
        busy   = (state_r == ST_ENC) || (state_r == ST_XMIT);
        flip_s = err_en && ((cnt_r == err_addr1) || (cnt_r == err_addr2));
        if (state_r == ST_XMIT) line_bit = mem_r[cnt_r] ^ flip_s;
        else                    line_bit = 1'b0;

        p1_s = group_parity(mem_r, 16'hAAAA);
        p2_s = group_parity(mem_r, 16'hCCCC);
        p4_s = group_parity(mem_r, 16'hF0F0);
        p8_s = group_parity(mem_r, 16'hFF00);
        enc_frame_s    = mem_r;
        enc_frame_s[1] = p1_s;
        enc_frame_s[2] = p2_s;
        enc_frame_s[4] = p4_s;
        enc_frame_s[8] = p8_s;
        enc_frame_s[0] = ^enc_frame_s[15:1];

        par_next_s        = dec_parity ^ line_bit;
        chk_next_s        = dec_check ^ (cnt_r & {4{line_bit}});
        rx_full_s         = rx_r;
        rx_full_s[cnt_r]  = line_bit;
        // A syndrome of 0 lands on position 0, which carries no data.
        corrected_s = rx_full_s ^ ({15'd0, par_next_s} << chk_next_s);
    end

    // State, frame memory and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_LOAD;
            cnt_r      <= 4'd0;
            mem_r      <= 16'd0;
            rx_r       <= 16'd0;
            enc_parity <= 1'b0;
            enc_group  <= 4'd0;
            done       <= 1'b0;
            dec_parity <= 1'b0;
            dec_check  <= 4'd0;
            no_err     <= 1'b0;
            single_err <= 1'b0;
            double_err <= 1'b0;
            data_out   <= 11'd0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_LOAD: begin
                    if (din_valid) begin
                        mem_r[cnt_r] <= is_reserved(cnt_r) ? 1'b0 : din;
                        cnt_r        <= cnt_r + 4'd1;
                        if (cnt_r == 4'd0) begin
                            enc_parity <= 1'b0;
                            enc_group  <= 4'd0;
                        end
                    end
                end
                ST_ENC: begin
                    mem_r      <= enc_frame_s;
                    enc_parity <= enc_frame_s[0];
                    enc_group  <= {p1_s, p2_s, p4_s, p8_s};
                    rx_r       <= 16'd0;
                    dec_parity <= 1'b0;
                    dec_check  <= 4'd0;
                    cnt_r      <= 4'd0;
                end
                ST_XMIT: begin
                    rx_r[cnt_r] <= line_bit;
                    dec_parity  <= par_next_s;
                    dec_check   <= chk_next_s;
                    cnt_r       <= cnt_r + 4'd1;
                    if (cnt_r == 4'd15) begin
                        done       <= 1'b1;
                        no_err     <= !par_next_s && (chk_next_s == 4'd0);
                        single_err <= par_next_s;
                        double_err <= !par_next_s && (chk_next_s != 4'd0);
                        data_out   <= extract_data(corrected_s);
                    end
                end
                ST_DONE: begin
                    if (din_valid) begin
                        mem_r[0]   <= 1'b0;
                        cnt_r      <= 4'd1;
                        done       <= 1'b0;
                        no_err     <= 1'b0;
                        single_err <= 1'b0;
                        double_err <= 1'b0;
                        enc_parity <= 1'b0;
                        enc_group  <= 4'd0;
                    end
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming16_link.sv
// Table-driven bench for hamming16_link with hand-computed encode/decode results,
// plus sequences for load gaps and a reset in the middle of transmission.
module tb_hamming16_link;

    logic        clk = 1'b0;
    logic        rst, din, din_valid, err_en;
    logic [3:0]  err_addr1, err_addr2;
    logic        busy, enc_parity, line_bit, done, dec_parity;
    logic        no_err, single_err, double_err;
    logic [3:0]  enc_group, dec_check;
    logic [10:0] data_out;

    int total = 0;
    int bad   = 0;

    hamming16_link dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .err_en(err_en), .err_addr1(err_addr1), .err_addr2(err_addr2),
        .busy(busy), .enc_parity(enc_parity), .enc_group(enc_group),
        .line_bit(line_bit), .done(done), .dec_parity(dec_parity),
        .dec_check(dec_check), .no_err(no_err), .single_err(single_err),
        .double_err(double_err), .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] frame;
        logic        en;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic        ep;
        logic [3:0]  eg;
        logic        dp;
        logic [3:0]  dc;
        logic [2:0]  flags;   // {no_err, single_err, double_err}
        logic [10:0] data;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [15:0] f, input logic e, input logic [3:0] a1,
                             input logic [3:0] a2, input bit gap, output int lat);
        err_en    = e;
        err_addr1 = a1;
        err_addr2 = a2;
        for (int i = 0; i < 16; i++) begin
            if (gap && (i == 9 || i == 12)) begin
                din_valid = 1'b0;
                din       = 1'b1;
                tick();
            end
            din       = f[i];
            din_valid = 1'b1;
            tick();
            if (i == 0) begin
                chk("done_clears", 32'(done), 32'd0);
                chk("flags_clear", 32'({no_err, single_err, double_err}), 32'd0);
            end
        end
        din_valid = 1'b0;
        din       = 1'b0;
        chk("busy_after_load", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_results(input vec_t v, input int lat);
        chk("latency",    32'(lat),        32'd17);
        chk("enc_parity", 32'(enc_parity), 32'(v.ep));
        chk("enc_group",  32'(enc_group),  32'(v.eg));
        chk("dec_parity", 32'(dec_parity), 32'(v.dp));
        chk("dec_check",  32'(dec_check),  32'(v.dc));
        chk("flags",      32'({no_err, single_err, double_err}), 32'(v.flags));
        chk("data_out",   32'(data_out),   32'(v.data));
        chk("busy_done",  32'(busy),       32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, 32'({busy, enc_parity, enc_group, line_bit, done, dec_parity,
                                 dec_check, no_err, single_err, double_err}), 32'd0);
        chk({tag, "_data"}, 32'(data_out), 32'd0);
    endtask

    initial begin
        int lat;
        // Data bits at positions 6,7,11,13,14.
        vecs[0] = '{16'h68C0, 1'b0, 4'd0,  4'd0,  1'b1, 4'b1001, 1'b0, 4'h0, 3'b100, 11'h34C};
        vecs[1] = '{16'h68C0, 1'b1, 4'd12, 4'd12, 1'b1, 4'b1001, 1'b1, 4'hC, 3'b010, 11'h34C};
        vecs[2] = '{16'h68C0, 1'b1, 4'd3,  4'd12, 1'b1, 4'b1001, 1'b0, 4'hF, 3'b001, 11'h3CD};
        vecs[3] = '{16'h68C0, 1'b1, 4'd0,  4'd0,  1'b1, 4'b1001, 1'b1, 4'h0, 3'b010, 11'h34C};
        vecs[4] = '{16'h68C0, 1'b1, 4'd8,  4'd8,  1'b1, 4'b1001, 1'b1, 4'h8, 3'b010, 11'h34C};
        vecs[5] = '{16'h0000, 1'b0, 4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 4'h0, 3'b100, 11'h000};
        vecs[6] = '{16'hFFFF, 1'b0, 4'd0,  4'd0,  1'b1, 4'b1111, 1'b0, 4'h0, 3'b100, 11'h7FF};
        vecs[7] = '{16'hFFFF, 1'b1, 4'd5,  4'd5,  1'b1, 4'b1111, 1'b1, 4'h5, 3'b010, 11'h7FF};

        rst = 1'b1; din = 1'b0; din_valid = 1'b0;
        err_en = 1'b0; err_addr1 = 4'd0; err_addr2 = 4'd0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].frame, vecs[v].en, vecs[v].a1, vecs[v].a2, 1'b0, lat);
            check_results(vecs[v], lat);
            tick();
            chk("done_holds", 32'(done), 32'd1);
        end

        // Load with din_valid gaps carrying din=1 that must be ignored.
        run_frame(16'h68C0, 1'b0, 4'd0, 4'd0, 1'b1, lat);
        check_results(vecs[0], lat);

        // Reset while transmitting position 5.
        err_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            din = vecs[0].frame[i];
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        din = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("mid_xmit_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        tick();
        run_frame(vecs[1].frame, vecs[1].en, vecs[1].a1, vecs[1].a2, 1'b0, lat);
        check_results(vecs[1], lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
